hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It consumes the per-stage control bits and register indices that the decode-side controller pipelines forward (regwrite/memtoreg in E/M/W, branch/jr in D), plus bus-busy and exception events. It produces the stallX/flushX inputs that the controller and datapath pipeline registers take back, and the forwarding selects. It owns the only sequential hazard state: the multi-cycle divide timer and a deferred exception flush.

## Interface
Parameters:
- DIV_CYCLES, 32, cycles a divide occupies E (≥2)
- REG_W, 5, register index width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rsD, rtD, rsE, rtE  in  REG_W  source indices in D and E
- writeregE, writeregM, writeregW  in  REG_W  destination index per stage
- regwriteE, regwriteM, regwriteW  in  1  stage writes register file
- memtoregE, memtoregM  in  1  stage is a load
- branchD, jrD  in  1  D holds branch / jr (resolved in D)
- div_startE  in  1  divide instruction present in E
- i_stall, d_stall  in  1  instruction / data bus not ready
- exceptM  in  1  exception taken by instruction in M
- forwardaD, forwardbD  out  1  D-stage compare operand from M
- forwardaE, forwardbE  out  2  E operand select: 00 regfile, 01 W, 10 M
- stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
- flushD, flushE, flushM, flushW  out  1  clear stage register
- div_busy  out  1  divide in progress
- div_done  out  1  one-cycle pulse, divide result valid

## Operation
- Index 0 never matches in any hazard/forward compare.
- forwardaE = 10 if regwriteM & writeregM==rsE; else 01 if regwriteW & writeregW==rsE; else 00. M wins over W. Same for forwardbE with rtE.
- forwardaD = regwriteM & writeregM==rsD; forwardbD with rtD.
- lwstall = memtoregE & regwriteE & writeregE∈{rsD,rtD}.
- brstall = (branchD|jrD) & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- memstall = i_stall | d_stall.
- divstall = (state==BUSY) | (state==IDLE & div_startE).
- stallF = stallD = lwstall|brstall|divstall|memstall; stallE = divstall|memstall; stallM = stallW = memstall.
- flushE = (lwstall|brstall) & ~divstall & ~memstall (bubble into E).
- Exception: eff_exc = (exceptM | exc_pending) & ~memstall drives flushD/E/M/W=1, overriding all stalls to 0 that cycle. exceptM during memstall sets exc_pending; cleared when eff_exc fires.
- Divide FSM: IDLE → BUSY on div_startE & ~eff_exc, counter loaded DIV_CYCLES-2; BUSY decrements each cycle, → DONE at 0; DONE → IDLE. div_busy=1 in BUSY, div_done=1 in DONE (stallE released that cycle). Counter frozen while memstall. eff_exc in BUSY/DONE → IDLE next cycle, no div_done.

## Timing
- While rst=1 and the cycle after: all stall/flush 0, div_busy/div_done 0, state IDLE, counter 0, exc_pending 0.
- Forwarding, stall and flush outputs are combinational from inputs plus registered state; zero-cycle latency.
- Divide holds E for exactly DIV_CYCLES cycles (first cycle IDLE-detect, then BUSY, last cycle DONE) absent memstall.
- exceptM and memstall same cycle: no flush that cycle; flush on first memstall-free cycle.
- rst mid-divide: FSM to IDLE, no div_done.

## Structure
- Shared package: FSM state enum (IDLE, BUSY, DONE), FWD_RF=00/FWD_W=01/FWD_M=10, default DIV_CYCLES.
- One sub-module: div_timer (FSM + down-counter, outputs divstall/div_busy/div_done, inputs start/abort/freeze).

## Test plan
- regwriteM=1 writeregM=8, regwriteW=1 writeregW=8, rsE=8 -> forwardaE=10; writeregM=0 with rsE=0 -> 00.
- memtoregE=regwriteE=1 writeregE=9, rtD=9 -> stallF=stallD=flushE=1, stallE=0 for one cycle.
- div_startE pulse, DIV_CYCLES=32 -> stallE=1 for 31 cycles, div_done=1 on 32nd, stallE=0 then.
- d_stall=1 during BUSY for 5 cycles -> done delayed exactly 5 cycles.
- exceptM=1 while i_stall=1 for 3 cycles -> no flush until i_stall drops; then flushD/E/M/W=1 one cycle.
- rst=1 at BUSY count 10 -> next cycle div_busy=0, all stalls 0, no div_done.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its divide timer.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int DEFAULT_DIV_CYCLES = 32;
    localparam int DEFAULT_REG_W      = 5;

endpackage

// File: rtl/hazard_ctrl_div_timer.sv
// Multi-cycle divide occupancy timer: holds E from the detect cycle until the result is ready.
module div_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic freeze,
    output logic divstall,
    output logic div_busy,
    output logic div_done
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    divState_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // Counter holds the number of BUSY cycles still to come, including the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        cnt_q <= LOAD;
                        if (LOAD == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (freeze) begin
                        busy_q <= 1'b1;
                    end else if (cnt_q == ONE) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q - ONE;
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign divstall = (state_q == BUSY) || ((state_q == IDLE) && start);
    assign div_busy = busy_q;
    assign div_done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, stall and forwarding controller for the five-stage MIPS pipeline.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES,
    parameter int REG_W      = DEFAULT_REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             jrD,
    input  logic             div_startE,
    input  logic             i_stall,
    input  logic             d_stall,
    input  logic             exceptM,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             div_busy,
    output logic             div_done
);

    logic rstDly_q;
    logic excPending_q;
    logic excPending_d;
    logic quiet;
    logic memStall;
    logic lwStall;
    logic brStall;
    logic divStall;
    logic hazStall;
    logic effExc;
    logic timerBusy;
    logic timerDone;

    function automatic logic regHit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Outputs are silenced during reset and for one cycle after it.
    assign quiet    = rst || rstDly_q;
    assign memStall = i_stall || d_stall;
    assign effExc   = (exceptM || excPending_q) && !memStall && !quiet;

    assign excPending_d = (exceptM || excPending_q) && !effExc;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstDly_q     <= 1'b1;
            excPending_q <= 1'b0;
        end else begin
            rstDly_q     <= 1'b0;
            excPending_q <= excPending_d;
        end
    end

    div_timer #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (div_startE && !rstDly_q),
        .abort   (effExc),
        .freeze  (memStall),
        .divstall(divStall),
        .div_busy(timerBusy),
        .div_done(timerDone)
    );

    always_comb begin
        forwardaE = FWD_RF;
        if (regwriteM && regHit(writeregM, rsE)) begin
            forwardaE = FWD_M;
        end else if (regwriteW && regHit(writeregW, rsE)) begin
            forwardaE = FWD_W;
        end
        forwardbE = FWD_RF;
        if (regwriteM && regHit(writeregM, rtE)) begin
            forwardbE = FWD_M;
        end else if (regwriteW && regHit(writeregW, rtE)) begin
            forwardbE = FWD_W;
        end
    end

    assign forwardaD = regwriteM && regHit(writeregM, rsD);
    assign forwardbD = regwriteM && regHit(writeregM, rtD);

    assign lwStall = memtoregE && regwriteE &&
                     (regHit(writeregE, rsD) || regHit(writeregE, rtD));
    assign brStall = (branchD || jrD) &&
                     ((regwriteE && (regHit(writeregE, rsD) || regHit(writeregE, rtD))) ||
                      (memtoregM && (regHit(writeregM, rsD) || regHit(writeregM, rtD))));
    assign hazStall = lwStall || brStall || divStall || memStall;

    // A taken exception flushes everything and overrides every stall.
    assign stallF = !quiet && !effExc && hazStall;
    assign stallD = !quiet && !effExc && hazStall;
    assign stallE = !quiet && !effExc && (divStall || memStall);
    assign stallM = !quiet && !effExc && memStall;
    assign stallW = !quiet && !effExc && memStall;

    assign flushD = effExc;
    assign flushE = !quiet && (effExc || ((lwStall || brStall) && !divStall && !memStall));
    assign flushM = effExc;
    assign flushW = effExc;

    assign div_busy = timerBusy && !quiet;
    assign div_done = timerDone && !quiet && !effExc;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios followed by randomized traffic.
module tb_hazard_ctrl;

    localparam int DIVC = 32;

    typedef struct packed {
        logic       rst;
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM, brD, jrD, divS, iSt, dSt, exc;
    } stim_t;

    typedef struct packed {
        logic [5:0] fwd;
        logic [4:0] stall;
        logic [3:0] flush;
        logic [1:0] dv;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jrD, div_startE, i_stall, d_stall, exceptM;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE, flushM, flushW;
    logic       div_busy, div_done;

    exp_t expQ[$];
    int   nVectors = 0;
    int   nMiscompares = 0;

    int   divAge = -1;
    logic owed = 1'b0;
    logic prevRst = 1'b1;

    hazard_ctrl #(.DIV_CYCLES(DIVC), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .div_startE(div_startE),
        .i_stall(i_stall), .d_stall(d_stall), .exceptM(exceptM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_busy(div_busy), .div_done(div_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s      = '0;
        s.rst  = ($urandom_range(0, 199) == 0);
        s.rsD  = 5'($urandom_range(0, 3));
        s.rtD  = 5'($urandom_range(0, 3));
        s.rsE  = 5'($urandom_range(0, 3));
        s.rtE  = 5'($urandom_range(0, 3));
        s.wE   = 5'($urandom_range(0, 3));
        s.wM   = 5'($urandom_range(0, 3));
        s.wW   = 5'($urandom_range(0, 3));
        s.rwE  = 1'($urandom_range(0, 1));
        s.rwM  = 1'($urandom_range(0, 1));
        s.rwW  = 1'($urandom_range(0, 1));
        s.mtrE = ($urandom_range(0, 3) == 0);
        s.mtrM = ($urandom_range(0, 3) == 0);
        s.brD  = ($urandom_range(0, 4) == 0);
        s.jrD  = ($urandom_range(0, 9) == 0);
        s.divS = ($urandom_range(0, 59) == 0);
        s.iSt  = ($urandom_range(0, 9) == 0);
        s.dSt  = ($urandom_range(0, 9) == 0);
        s.exc  = ($urandom_range(0, 39) == 0);
        return s;
    endfunction

    // Drive one cycle of inputs, predict the outputs from the pipeline rules, then advance the model.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        logic quiet, mem, effExc, lw, br, divSt, startEff, haz;
        logic [1:0] fa, fb;
        @(posedge clk);
        #1;
        rst = s.rst; rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
        writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
        regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
        memtoregE = s.mtrE; memtoregM = s.mtrM; branchD = s.brD; jrD = s.jrD;
        div_startE = s.divS; i_stall = s.iSt; d_stall = s.dSt; exceptM = s.exc;

        quiet    = s.rst || prevRst;
        mem      = s.iSt || s.dSt;
        startEff = s.divS && !prevRst;
        effExc   = (s.exc || owed) && !mem && !quiet;

        if (s.rwM && s.wM != 0 && s.wM == s.rsE)      fa = 2'b10;
        else if (s.rwW && s.wW != 0 && s.wW == s.rsE) fa = 2'b01;
        else                                          fa = 2'b00;
        if (s.rwM && s.wM != 0 && s.wM == s.rtE)      fb = 2'b10;
        else if (s.rwW && s.wW != 0 && s.wW == s.rtE) fb = 2'b01;
        else                                          fb = 2'b00;
        e.fwd = {s.rwM && s.wM != 0 && s.wM == s.rsD,
                 s.rwM && s.wM != 0 && s.wM == s.rtD, fa, fb};

        lw = s.mtrE && s.rwE && s.wE != 0 && (s.wE == s.rsD || s.wE == s.rtD);
        br = (s.brD || s.jrD) &&
             ((s.rwE && s.wE != 0 && (s.wE == s.rsD || s.wE == s.rtD)) ||
              (s.mtrM && s.wM != 0 && (s.wM == s.rsD || s.wM == s.rtD)));
        divSt = (divAge < 0) ? startEff : (divAge < DIVC - 1);
        haz   = lw || br || divSt || mem;

        if (quiet || effExc) e.stall = '0;
        else                 e.stall = {haz, haz, divSt || mem, mem, mem};
        e.flush = {effExc, !quiet && (effExc || ((lw || br) && !divSt && !mem)), effExc, effExc};
        e.dv = {!quiet && divAge >= 1 && divAge <= DIVC - 2,
                !quiet && !effExc && divAge == DIVC - 1};
        expQ.push_back(e);

        if (s.rst) begin
            divAge = -1;
            owed   = 1'b0;
        end else begin
            owed = (s.exc || owed) && !effExc;
            if (effExc)                divAge = -1;
            else if (divAge < 0)       divAge = startEff ? 1 : -1;
            else if (divAge == DIVC-1) divAge = -1;
            else if (!mem)             divAge = divAge + 1;
        end
        prevRst = s.rst;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] want);
        nVectors++;
        if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL %s t=%0t got=%b expected=%b", name, $time, got, want);
        end
    endtask

    // Monitor: the outputs are combinational, so the DUT presents a result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("forward", {forwardaD, forwardbD, forwardaE, forwardbE}, e.fwd);
                checkOutput("stall", {1'b0, stallF, stallD, stallE, stallM, stallW}, {1'b0, e.stall});
                checkOutput("flush", {2'b00, flushD, flushE, flushM, flushW}, {2'b00, e.flush});
                checkOutput("divide", {4'b0000, div_busy, div_done}, {4'b0000, e.dv});
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, jrD, div_startE, i_stall, d_stall, exceptM} = '0;

        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        repeat (2) applyStimulus(idleStim());

        s = idleStim(); s.rwM = 1; s.wM = 8; s.rwW = 1; s.wW = 8; s.rsE = 8; s.rsD = 8;
        applyStimulus(s);
        s = idleStim(); s.rwM = 1; s.wM = 0; s.rsE = 0; s.rwW = 1; s.wW = 3; s.rtE = 3;
        applyStimulus(s);

        s = idleStim(); s.mtrE = 1; s.rwE = 1; s.wE = 9; s.rtD = 9;
        applyStimulus(s);
        s = idleStim(); s.brD = 1; s.mtrM = 1; s.wM = 4; s.rsD = 4;
        applyStimulus(s);
        applyStimulus(idleStim());

        s = idleStim(); s.divS = 1;
        applyStimulus(s);
        repeat (DIVC + 2) applyStimulus(idleStim());

        s = idleStim(); s.divS = 1;
        applyStimulus(s);
        repeat (10) applyStimulus(idleStim());
        s = idleStim(); s.dSt = 1;
        repeat (5) applyStimulus(s);
        repeat (DIVC) applyStimulus(idleStim());

        s = idleStim(); s.exc = 1; s.iSt = 1;
        repeat (3) applyStimulus(s);
        repeat (3) applyStimulus(idleStim());

        s = idleStim(); s.divS = 1;
        applyStimulus(s);
        repeat (20) applyStimulus(idleStim());
        s = idleStim(); s.rst = 1;
        applyStimulus(s);
        repeat (4) applyStimulus(idleStim());

        repeat (2500) applyStimulus(randStim());
        repeat (DIVC + 2) applyStimulus(idleStim());

        @(posedge clk);
        @(negedge clk);
        #1;
        nVectors++;
        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain got=%0d pending expected=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
